// File: rtl/mult_nibble_seq.sv
// Sequential unsigned WIDTH_A x WIDTH_B multiplier built on one 4x4 nibble product.
// Optional: define MULT_NIBBLE_SEQ_ZERO_SKIP_EN to skip rows whose A nibble is zero.
module mult_nibble_seq #(
  parameter int WIDTH_A = 16,
  parameter int WIDTH_B = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH_A-1:0]         a,
  input  logic [WIDTH_B-1:0]         b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH_A+WIDTH_B-1:0] p,
  output logic                       busy
);

  localparam int NA = WIDTH_A / 4;
  localparam int NB = WIDTH_B / 4;
  localparam int PW = WIDTH_A + WIDTH_B;
  localparam int IW = (NA > 1) ? $clog2(NA) : 1;
  localparam int JW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t             state;
  logic [WIDTH_A-1:0] a_r;
  logic [WIDTH_B-1:0] b_r;
  logic [IW-1:0]      i;
  logic [JW-1:0]      j;
  logic [PW-1:0]      acc;

  logic [3:0]         nib_a;
  logic [3:0]         nib_b;
  logic [7:0]         pp;
  logic [6:0]         sh;
  logic [PW-1:0]      term;
  logic               last_i;
  logic               last_j;
  logic               skip;

  always_comb begin
    nib_a  = 4'(a_r >> {i, 2'b00});
    nib_b  = 4'(b_r >> {j, 2'b00});
    pp     = {4'b0, nib_a} * {4'b0, nib_b};
    sh     = 7'({i, 2'b00}) + 7'({j, 2'b00});
    term   = PW'(pp) << sh;
    last_i = (i == IW'(NA - 1));
    last_j = (j == JW'(NB - 1));
`ifdef MULT_NIBBLE_SEQ_ZERO_SKIP_EN
    skip   = (j == '0) && (nib_a == 4'd0);
`else
    skip   = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      i     <= '0;
      j     <= '0;
      acc   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            acc   <= '0;
            i     <= '0;
            j     <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (skip) begin
            j <= '0;
            if (last_i) state <= DONE;
            else        i     <= i + 1'b1;
          end else begin
            acc <= acc + term;
            if (last_j) begin
              j <= '0;
              if (last_i) state <= DONE;
              else        i     <= i + 1'b1;
            end else begin
              j <= j + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake flags decode straight from the state register.
  assign in_ready  = (state == IDLE);
  assign busy      = (state == BUSY);
  assign out_valid = (state == DONE);
  assign p         = acc;

endmodule

// File: tb/tb_mult_nibble_seq.sv
// Directed + random bench for mult_nibble_seq across several width pairs.
// Expected products are queued on acceptance and checked when out_valid rises.
module tb_mult_nibble_seq;

  localparam int NDUT = 6;

  function automatic int wa_of(int k);
    case (k)
      0: return 16; 1: return 8;  2: return 4;
      3: return 32; 4: return 4;  default: return 32;
    endcase
  endfunction

  function automatic int wb_of(int k);
    case (k)
      0: return 16; 1: return 12; 2: return 4;
      3: return 32; 4: return 32; default: return 8;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst;
  logic        iv   [NDUT];
  logic        ird  [NDUT];
  logic        ov   [NDUT];
  logic        ordy [NDUT];
  logic        bsy  [NDUT];
  logic [31:0] aa   [NDUT];
  logic [31:0] bb   [NDUT];
  logic [63:0] pp   [NDUT];

  int checks   = 0;
  int failures = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int WA = wa_of(g);
    localparam int WB = wb_of(g);
    logic [WA+WB-1:0] pw;
    mult_nibble_seq #(.WIDTH_A(WA), .WIDTH_B(WB)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (iv[g]),
      .in_ready (ird[g]),
      .a        (aa[g][WA-1:0]),
      .b        (bb[g][WB-1:0]),
      .out_valid(ov[g]),
      .out_ready(ordy[g]),
      .p        (pw),
      .busy     (bsy[g])
    );
    assign pp[g] = 64'(pw);
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mask(logic [31:0] v, int w);
    logic [31:0] m;
    m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return v & m;
  endfunction

  // Reference edge count from acceptance to out_valid.
  function automatic int lat_of(int k, logic [31:0] v);
    int l = 0;
    for (int r = 0; r < wa_of(k) / 4; r++) begin
`ifdef MULT_NIBBLE_SEQ_ZERO_SKIP_EN
      logic [3:0] nib;
      nib = 4'(v >> (4 * r));
      l += (nib == 4'd0) ? 1 : wb_of(k) / 4;
`else
      l += wb_of(k) / 4;
`endif
    end
    return l;
  endfunction

  task automatic do_op(input int k, input logic [31:0] av,
                       input logic [31:0] bv, input int hold,
                       input bit pulse, input bit keep, input bit imm);
    int n, e, lat;
    bit busy_ok;
    logic [31:0] am, bm;
    logic [63:0] exp_p;
    am = mask(av, wa_of(k));
    bm = mask(bv, wb_of(k));
    aa[k] = av; bb[k] = bv; iv[k] = 1'b1; ordy[k] = 1'b0;
    n = 0;
    while (!ird[k] && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_wait", 64'(ird[k]), 64'd1);
    if (imm) chk("accept_immediate", 64'(n), 64'd0);
    sb.push_back(64'(am) * 64'(bm));
    lat = lat_of(k, am);
    @(posedge clk); #1;
    if (!keep) iv[k] = 1'b0;
    chk("accepted_busy", {62'd0, bsy[k], ird[k]}, 64'b10);
    e = 0;
    busy_ok = 1'b1;
    while (!ov[k] && e < 300) begin
      if (pulse) begin
        iv[k] = e[0];
        aa[k] = ~av;
      end
      if (bsy[k] !== 1'b1 || ird[k] !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1; e++;
    end
    chk("busy_span", 64'(busy_ok), 64'd1);
    chk("latency", 64'(e), 64'(lat));
    chk("done_flags", {61'd0, ov[k], ird[k], bsy[k]}, 64'b100);
    exp_p = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD;
    chk("product", pp[k], exp_p);
    for (int h = 0; h < hold; h++) begin
      if (pulse) iv[k] = 1'b1;
      @(posedge clk); #1;
      chk("hold", {pp[k][61:0], ov[k], ird[k]}, {exp_p[61:0], 2'b10});
    end
    if (!keep) iv[k] = 1'b0;
    ordy[k] = 1'b1;
    @(posedge clk); #1;
    ordy[k] = 1'b0;
    chk("retire_flags", {61'd0, ov[k], ird[k], bsy[k]}, 64'b010);
    chk("retire_p_held", pp[k], exp_p);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b0; aa[k] = '0; bb[k] = '0;
    end
    #12;
    chk("reset_state", {pp[0][60:0], ird[0], ov[0], bsy[0]}, 64'b100);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(0, 32'hFFFF, 32'hFFFF, 0, 1'b0, 1'b0, 1'b0);
    do_op(0, 32'h1234, 32'h5678, 5, 1'b1, 1'b0, 1'b0);
    do_op(0, 32'd3, 32'd5, 0, 1'b0, 1'b1, 1'b0);
    do_op(0, 32'h00FF, 32'h0100, 0, 1'b0, 1'b0, 1'b1);

    // Abort an operation part-way through BUSY.
    aa[0] = 32'hFFFF; bb[0] = 32'hFFFF; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    chk("async_reset", {pp[0][60:0], ird[0], ov[0], bsy[0]}, 64'b100);
    rst = 1'b0;
    @(posedge clk); #1;
    do_op(0, 32'd7, 32'd9, 0, 1'b0, 1'b0, 1'b0);

    do_op(0, 32'h0, 32'h0, 1, 1'b0, 1'b0, 1'b0);
    do_op(0, 32'h00F0, 32'h1234, 0, 1'b0, 1'b0, 1'b0);
    do_op(1, 32'hAB, 32'hCDE, 0, 1'b0, 1'b0, 1'b0);
    do_op(2, 32'hF, 32'hF, 0, 1'b0, 1'b0, 1'b0);
    do_op(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 1'b0);

    for (int k = 1; k < NDUT; k++) begin
      for (int r = 0; r < 3; r++) begin
        do_op(k, $urandom, $urandom, r, 1'b0, 1'b0, 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
